// File: rtl/invaders_pkg.sv
// Field widths and bullet state encoding shared by the formation block, the
// player bullet and the VGA renderer.
package invaders_pkg;

  localparam int X_W     = 5;
  localparam int Y_W     = 4;
  localparam int X_MAX   = 19;
  localparam int ROW_MAX = 14;

  typedef enum logic [1:0] {
    BULLET_IDLE     = 2'd0,
    BULLET_FLIGHT   = 2'd1,
    BULLET_COOLDOWN = 2'd2
  } bullet_state_t;

endpackage

// File: rtl/step_timer.sv
// Modulo-N cycle counter: o_tick is high for the one cycle in which the count
// sits at N-1; the count then wraps to 0. i_clear restarts the period.
module step_timer #(
  parameter int N = 4
) (
  input  logic i_clk_36MHz,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int               CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge i_clk_36MHz or posedge i_reset) begin
    if (i_reset) begin
      count_reg <= '0;
    end else if (i_clear || (count_reg == LAST)) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign o_tick = (count_reg == LAST);

endmodule

// File: rtl/player_bullet.sv
// Player cannon position and the single player bullet: launch on a fire press,
// step up the field, retire on a formation hit or on leaving the top row.
module player_bullet
  import invaders_pkg::*;
#(
  parameter int BULLET_SPEED = 30000,
  parameter int MOVE_SPEED   = 100000,
  parameter int COOLDOWN     = 4,
  parameter int START_Y      = 14,
  parameter int X_MAX        = invaders_pkg::X_MAX,
  parameter int PLAYER_X_RST = 10
) (
  input  logic           i_clk_36MHz,
  input  logic           i_reset,
  input  logic           i_fire,
  input  logic           i_left,
  input  logic           i_right,
  input  logic           i_hit,
  output logic [X_W-1:0] o_bullet_x,
  output logic [Y_W-1:0] o_bullet_y,
  output logic           o_bullet_active,
  output logic [X_W-1:0] o_player_x,
  output logic           o_kill,
  output logic           o_miss
);

  localparam int              CD_W    = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CD_W-1:0] CD_LAST = CD_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

  bullet_state_t  state_reg, state_next;
  logic           fire_q_reg;
  logic [X_W-1:0] bullet_x_reg, bullet_x_next;
  logic [Y_W-1:0] bullet_y_reg, bullet_y_next;
  logic           active_reg, active_next;
  logic           kill_reg, kill_next;
  logic           miss_reg, miss_next;
  logic [X_W-1:0] player_x_reg, player_x_next;
  logic [CD_W-1:0] cd_cnt_reg, cd_cnt_next;

  logic fire_edge, launch, retire_hit, retire_miss, cd_done;
  logic bullet_tick, move_tick, bullet_clear;

  assign fire_edge    = i_fire & ~fire_q_reg;
  assign launch       = (state_reg == BULLET_IDLE) && fire_edge;
  assign retire_hit   = (state_reg == BULLET_FLIGHT) && i_hit;
  // A hit outranks a step landing in the same cycle.
  assign retire_miss  = (state_reg == BULLET_FLIGHT) && !i_hit && bullet_tick &&
                        (bullet_y_reg == Y_W'(1));
  assign cd_done      = (state_reg == BULLET_COOLDOWN) && bullet_tick && (cd_cnt_reg == CD_LAST);
  assign bullet_clear = launch | retire_hit | retire_miss;

  step_timer #(.N(BULLET_SPEED)) u_bullet_timer (
    .i_clk_36MHz (i_clk_36MHz),
    .i_reset     (i_reset),
    .i_clear     (bullet_clear),
    .o_tick      (bullet_tick)
  );

  step_timer #(.N(MOVE_SPEED)) u_move_timer (
    .i_clk_36MHz (i_clk_36MHz),
    .i_reset     (i_reset),
    .i_clear     (1'b0),
    .o_tick      (move_tick)
  );

  always_ff @(posedge i_clk_36MHz or posedge i_reset) begin
    if (i_reset) begin
      state_reg    <= BULLET_IDLE;
      fire_q_reg   <= 1'b1;
      bullet_x_reg <= '0;
      bullet_y_reg <= '0;
      active_reg   <= 1'b0;
      kill_reg     <= 1'b0;
      miss_reg     <= 1'b0;
      player_x_reg <= X_W'(PLAYER_X_RST);
      cd_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      fire_q_reg   <= i_fire;
      bullet_x_reg <= bullet_x_next;
      bullet_y_reg <= bullet_y_next;
      active_reg   <= active_next;
      kill_reg     <= kill_next;
      miss_reg     <= miss_next;
      player_x_reg <= player_x_next;
      cd_cnt_reg   <= cd_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BULLET_IDLE: begin
        if (launch) state_next = BULLET_FLIGHT;
      end
      BULLET_FLIGHT: begin
        if (retire_hit || retire_miss)
          state_next = (COOLDOWN == 0) ? BULLET_IDLE : BULLET_COOLDOWN;
      end
      BULLET_COOLDOWN: begin
        if (cd_done) state_next = BULLET_IDLE;
      end
      default: state_next = BULLET_IDLE;
    endcase
  end

  always_comb begin
    bullet_x_next = bullet_x_reg;
    bullet_y_next = bullet_y_reg;
    active_next   = active_reg;
    kill_next     = 1'b0;
    miss_next     = 1'b0;
    cd_cnt_next   = cd_cnt_reg;
    case (state_reg)
      BULLET_IDLE: begin
        if (launch) begin
          bullet_x_next = player_x_reg;
          bullet_y_next = Y_W'(START_Y);
          active_next   = 1'b1;
        end
      end
      BULLET_FLIGHT: begin
        if (retire_hit || retire_miss) begin
          bullet_y_next = '0;
          active_next   = 1'b0;
          kill_next     = retire_hit;
          miss_next     = retire_miss;
          cd_cnt_next   = '0;
        end else if (bullet_tick) begin
          bullet_y_next = bullet_y_reg - 1'b1;
        end
      end
      BULLET_COOLDOWN: begin
        if (bullet_tick) cd_cnt_next = cd_cnt_reg + 1'b1;
      end
      default: ;
    endcase
  end

  // Cannon moves in every state and saturates at both edges.
  always_comb begin
    player_x_next = player_x_reg;
    if (move_tick) begin
      if (i_left && !i_right && (player_x_reg != '0))
        player_x_next = player_x_reg - 1'b1;
      else if (i_right && !i_left && (player_x_reg != X_W'(X_MAX)))
        player_x_next = player_x_reg + 1'b1;
    end
  end

  assign o_bullet_x      = bullet_x_reg;
  assign o_bullet_y      = bullet_y_reg;
  assign o_bullet_active = active_reg;
  assign o_player_x      = player_x_reg;
  assign o_kill          = kill_reg;
  assign o_miss          = miss_reg;

endmodule
